// File: rtl/nios2_rx_data_in_pio_if.sv
`timescale 1ns/1ps
// Avalon-MM slave bus plus level interrupt between the NIOS2 CPU and the RX data input PIO.
interface nios2_rx_data_in_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/nios2_rx_data_in_pio.sv
`timescale 1ns/1ps
// Input PIO: synchronised RX data register, per-bit edge capture, maskable level irq.
// Latency: readdata 1 clk after read edge; edgecapture sets SYNC_STAGES clks after in_port sample.
// Backpressure: none; slave accepts every access, no wait states.
module nios2_rx_data_in_pio #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    nios2_rx_data_in_pio_if.slave  bus,
    input  logic [WIDTH-1:0]       in_port
);

    localparam int ARM_CNT = SYNC_STAGES + 1;
    localparam int ARM_W   = $clog2(ARM_CNT + 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] irqmask_q;
    logic [WIDTH-1:0] edgecapture_q;
    logic [WIDTH-1:0] edgecapture_d;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] clr_mask;
    logic [ARM_W-1:0] arm_cnt_q;
    logic             armed;
    logic             wr_en;
    logic             rd_en;
    logic [31:0]      rd_mux;
    logic [31:0]      readdata_q;

    assign sync  = sync_q[SYNC_STAGES-1];
    assign armed = (arm_cnt_q == ARM_W'(ARM_CNT));
    assign wr_en = bus.chipselect & ~bus.write_n;
    assign rd_en = bus.chipselect &  bus.write_n;

    always_comb begin
        edge_det = '0;
        case (EDGE_TYPE)
            0:       edge_det =  sync & ~prev_q;
            1:       edge_det = ~sync &  prev_q;
            default: edge_det =  sync ^  prev_q;
        endcase
    end

    // A set in the same cycle as a write-1-to-clear takes priority.
    always_comb begin
        clr_mask = '0;
        if (wr_en && bus.address == 2'd3)
            clr_mask = bus.writedata[WIDTH-1:0];
        edgecapture_d = (edgecapture_q & ~clr_mask) | (armed ? edge_det : '0);
    end

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            2'd0:    rd_mux[WIDTH-1:0] = sync;
            2'd2:    rd_mux[WIDTH-1:0] = irqmask_q;
            2'd3:    rd_mux[WIDTH-1:0] = edgecapture_q;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++)
                sync_q[i] <= '0;
            prev_q        <= '0;
            arm_cnt_q     <= '0;
            irqmask_q     <= '0;
            edgecapture_q <= '0;
            readdata_q    <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++)
                sync_q[i] <= sync_q[i-1];
            prev_q <= sync;
            // Counter saturates once armed; only reset re-opens the blanking window.
            if (!armed)
                arm_cnt_q <= arm_cnt_q + ARM_W'(1);
            if (wr_en && bus.address == 2'd2)
                irqmask_q <= bus.writedata[WIDTH-1:0];
            edgecapture_q <= edgecapture_d;
            if (rd_en)
                readdata_q <= rd_mux;
        end
    end

    assign bus.readdata = readdata_q;
    assign bus.irq      = |(edgecapture_q & irqmask_q);

endmodule

// File: tb/tb_nios2_rx_data_in_pio.sv
`timescale 1ns/1ps
// Directed bench: rising-edge instance (dut0) and any-edge instance (dut2) share bus and in_port.
module tb_nios2_rx_data_in_pio;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] in_port = 32'hFFFF_FFFF;
    logic [31:0] rd0, rd2;
    logic        irq_seen;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    nios2_rx_data_in_pio_if bus0 ();
    nios2_rx_data_in_pio_if bus2 ();

    assign bus2.address    = bus0.address;
    assign bus2.chipselect = bus0.chipselect;
    assign bus2.write_n    = bus0.write_n;
    assign bus2.writedata  = bus0.writedata;

    nios2_rx_data_in_pio #(.WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(0)) dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0),
        .in_port (in_port)
    );

    nios2_rx_data_in_pio #(.WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(2)) dut2 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus2),
        .in_port (in_port)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus0.address    = addr;
        bus0.writedata  = data;
        bus0.chipselect = 1'b1;
        bus0.write_n    = 1'b0;
        @(negedge clk);
        bus0.chipselect = 1'b0;
        bus0.write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] addr, output logic [31:0] d0, output logic [31:0] d2);
        @(negedge clk);
        bus0.address    = addr;
        bus0.chipselect = 1'b1;
        bus0.write_n    = 1'b1;
        @(negedge clk);
        bus0.chipselect = 1'b0;
        d0 = bus0.readdata;
        d2 = bus2.readdata;
    endtask

    initial begin
        bus0.address    = 2'd0;
        bus0.chipselect = 1'b0;
        bus0.write_n    = 1'b1;
        bus0.writedata  = 32'h0;

        // Reset state with inputs held high
        #3;
        check("reset_readdata", bus0.readdata, 32'h0);
        check("reset_irq", {31'h0, bus0.irq}, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        irq_seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            irq_seen = irq_seen | bus0.irq | bus2.irq;
        end
        check("static_high_irq", {31'h0, irq_seen}, 32'h0);
        bus_read(2'd3, rd0, rd2);
        check("static_high_ec_rise", rd0, 32'h0);
        check("static_high_ec_any", rd2, 32'h0);
        bus_read(2'd0, rd0, rd2);
        check("data_all_ones", rd0, 32'hFFFF_FFFF);
        bus_read(2'd1, rd0, rd2);
        check("reserved_reads_0", rd0, 32'h0);

        // Rising edges on A5 with mask bit 0
        @(negedge clk);
        in_port = 32'h0;
        repeat (4) @(negedge clk);
        bus_write(2'd2, 32'h0000_0001);
        check("no_rise_on_fall", {31'h0, bus0.irq}, 32'h0);
        in_port = 32'h0000_00A5;
        @(negedge clk);
        @(negedge clk);
        check("irq_not_yet_k1", {31'h0, bus0.irq}, 32'h0);
        @(negedge clk);
        check("irq_at_k2", {31'h0, bus0.irq}, 32'h1);
        bus_read(2'd3, rd0, rd2);
        check("ec_A5", rd0, 32'h0000_00A5);
        bus_read(2'd2, rd0, rd2);
        check("irqmask_rb", rd0, 32'h0000_0001);

        // Write-1-to-clear
        bus_write(2'd3, 32'h0000_0001);
        check("irq_drop_after_clr", {31'h0, bus0.irq}, 32'h0);
        bus_read(2'd3, rd0, rd2);
        check("ec_A4", rd0, 32'h0000_00A4);
        bus_write(2'd3, 32'h0000_00A4);
        bus_read(2'd3, rd0, rd2);
        check("ec_cleared", rd0, 32'h0);
        bus_write(2'd0, 32'h1234_5678);
        bus_write(2'd1, 32'hFFFF_FFFF);
        bus_read(2'd0, rd0, rd2);
        check("data_ro", rd0, 32'h0000_00A5);
        bus_read(2'd1, rd0, rd2);
        check("reserved_ro", rd0, 32'h0);

        // Set and clear collide on bit 3
        bus_write(2'd2, 32'h0000_0008);
        in_port = 32'h0000_00AD;
        repeat (3) @(negedge clk);
        check("bit3_irq", {31'h0, bus0.irq}, 32'h1);
        in_port = 32'h0000_00A5;
        repeat (4) @(negedge clk);
        in_port = 32'h0000_00AD;
        @(negedge clk);
        bus_write(2'd3, 32'h0000_0008);
        check("collide_irq", {31'h0, bus0.irq}, 32'h1);
        bus_read(2'd3, rd0, rd2);
        check("collide_ec", rd0, 32'h0000_0008);
        bus_write(2'd3, 32'h0000_0008);
        check("clr_alone_irq", {31'h0, bus0.irq}, 32'h0);

        // Any-edge instance on bit 31
        in_port = 32'h8000_00AD;
        repeat (4) @(negedge clk);
        bus_write(2'd3, 32'hFFFF_FFFF);
        bus_write(2'd2, 32'h8000_0000);
        check("any_irq_idle", {31'h0, bus2.irq}, 32'h0);
        in_port = 32'h0000_00AD;
        repeat (3) @(negedge clk);
        check("any_irq_fall", {31'h0, bus2.irq}, 32'h1);
        bus_read(2'd3, rd0, rd2);
        check("any_ec_fall", rd2, 32'h8000_0000);
        check("rise_ignores_fall", rd0, 32'h0);
        bus_write(2'd3, 32'h8000_0000);
        check("any_irq_clr", {31'h0, bus2.irq}, 32'h0);
        in_port = 32'h8000_00AD;
        repeat (3) @(negedge clk);
        check("any_irq_rise", {31'h0, bus2.irq}, 32'h1);
        bus_read(2'd3, rd0, rd2);
        check("any_ec_rise", rd2, 32'h8000_0000);
        bus_write(2'd2, 32'h0);
        check("any_irq_unmasked", {31'h0, bus2.irq}, 32'h0);

        // Asynchronous reset mid-operation
        bus_write(2'd2, 32'hFFFF_FFFF);
        check("pre_reset_irq", {31'h0, bus0.irq}, 32'h1);
        bus_read(2'd2, rd0, rd2);
        check("pre_reset_mask", rd0, 32'hFFFF_FFFF);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_irq", {31'h0, bus0.irq}, 32'h0);
        check("async_readdata", bus0.readdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        bus_read(2'd2, rd0, rd2);
        check("post_reset_mask", rd0, 32'h0);
        bus_read(2'd3, rd0, rd2);
        check("post_reset_ec_any", rd2, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
